// File: rtl/pch_sequencer_if.sv
// PC high-byte sequencer bus: PC-low handshake, load buses and PCH outputs.
// The master side drives requests and load buses. The slave side (the sequencer)
// returns the PCH value and the status pulses.
interface pch_sequencer_if;
    logic       carry_to_pch;
    logic       borrow_to_pch;
    logic       adh_load;
    logic [7:0] address_high_in;
    logic       db_load;
    logic [7:0] db_in;
    logic [7:0] address_high_out;
    logic [7:0] db_out;
    logic       carry_done;
    logic       page_cross;
    logic       pch_wrap;
    logic       busy;

    modport master (
        output carry_to_pch, borrow_to_pch, adh_load, address_high_in, db_load, db_in,
        input  address_high_out, db_out, carry_done, page_cross, pch_wrap, busy
    );

    modport slave (
        input  carry_to_pch, borrow_to_pch, adh_load, address_high_in, db_load, db_in,
        output address_high_out, db_out, carry_done, page_cross, pch_wrap, busy
    );
endinterface

// File: rtl/pch_sequencer.sv
// PC high-byte (PCH) sequencer.
// PCH is loaded from ADH or DB, or stepped by one on a carry/borrow from the
// PC-low stage. Each accepted request is acknowledged once; the FSM then waits
// (optionally for the request to drop) before it will accept another.
module pch_sequencer #(
    parameter logic [7:0] RESET_PCH  = 8'h00,
    parameter bit         HOLD_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    pch_sequencer_if.slave bus
);

    localparam logic [0:0] ST_IDLE         = 1'b0;
    localparam logic [0:0] ST_WAIT_RELEASE = 1'b1;

    logic [7:0] pch_q, pch_d;
    logic [0:0] state_q, state_d;
    logic       carry_done_q, carry_done_d;
    logic       page_cross_q, page_cross_d;
    logic       pch_wrap_q, pch_wrap_d;

    logic       req;
    logic       load;
    logic [7:0] load_val;
    logic [8:0] adj;

    // Returns {wrap, next_pch} for a +1 (up) or -1 step modulo 256.
    function automatic logic [8:0] adjust_pch(input logic [7:0] pch, input logic up);
        logic [7:0] nxt;
        logic       wrap;
        nxt  = up ? pch + 8'd1 : pch - 8'd1;
        wrap = up ? (pch == 8'hFF) : (pch == 8'h00);
        return {wrap, nxt};
    endfunction

    assign req      = bus.carry_to_pch | bus.borrow_to_pch;
    assign load     = bus.adh_load | bus.db_load;
    assign load_val = bus.adh_load ? bus.address_high_in : bus.db_in;
    assign adj      = adjust_pch(pch_q, bus.carry_to_pch);

    // Next-state: ADH load beats DB load beats adjust; the adjust is only taken in IDLE.
    always_comb begin
        pch_d        = pch_q;
        state_d      = state_q;
        carry_done_d = 1'b0;
        page_cross_d = 1'b0;
        pch_wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    carry_done_d = 1'b1;
                    state_d      = ST_WAIT_RELEASE;
                    // Carry and borrow together cancel out: acknowledged, no step.
                    if (!load && (bus.carry_to_pch ^ bus.borrow_to_pch)) begin
                        pch_d        = adj[7:0];
                        page_cross_d = 1'b1;
                        pch_wrap_d   = adj[8];
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (!HOLD_CHECK || !req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            pch_d = load_val;
        end
    end

    // State and pulse registers; reset forces PCH and clears all status at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pch_q        <= RESET_PCH;
            state_q      <= ST_IDLE;
            carry_done_q <= 1'b0;
            page_cross_q <= 1'b0;
            pch_wrap_q   <= 1'b0;
        end else begin
            pch_q        <= pch_d;
            state_q      <= state_d;
            carry_done_q <= carry_done_d;
            page_cross_q <= page_cross_d;
            pch_wrap_q   <= pch_wrap_d;
        end
    end

    assign bus.address_high_out = pch_q;
    assign bus.db_out           = pch_q;
    assign bus.carry_done       = carry_done_q;
    assign bus.page_cross       = page_cross_q;
    assign bus.pch_wrap         = pch_wrap_q;
    assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pch_sequencer.sv
// Testbench for pch_sequencer: directed scenarios on a HOLD_CHECK=1 instance and
// a randomized run on HOLD_CHECK=1 and HOLD_CHECK=0 instances against a reference model.
module tb_pch_sequencer;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    pch_sequencer_if b1 ();
    pch_sequencer_if b0 ();

    pch_sequencer #(.RESET_PCH(8'hFF), .HOLD_CHECK(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );
    pch_sequencer #(.RESET_PCH(8'h3C), .HOLD_CHECK(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0)
    );

    always #5 clk = ~clk;

    // Reference model, index 0 = dut0 (no hold check), 1 = dut1 (hold check).
    // "armed" means a new carry/borrow request would be accepted.
    int m_pch   [2];
    bit m_armed [2];
    bit m_done  [2];
    bit m_pc    [2];
    bit m_wrap  [2];
    const int RST_VAL [2] = '{8'h3C, 8'hFF};
    const bit HOLD    [2] = '{1'b0, 1'b1};

    always @(posedge clk or negedge reset_n) begin
        int  p;
        bit  c, b, req, ld, arm, dn, pc, wr;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pch[i] <= RST_VAL[i]; m_armed[i] <= 1'b1;
                m_done[i] <= 1'b0; m_pc[i] <= 1'b0; m_wrap[i] <= 1'b0;
            end
        end else begin
            c   = b1.carry_to_pch;
            b   = b1.borrow_to_pch;
            req = c | b;
            ld  = b1.adh_load | b1.db_load;
            for (int i = 0; i < 2; i++) begin
                p = m_pch[i]; dn = 0; pc = 0; wr = 0; arm = m_armed[i];
                if (m_armed[i] && req) begin
                    dn  = 1;
                    arm = 0;
                    if (!ld && c && !b) begin
                        pc = 1; wr = (p == 255); p = (p + 1) % 256;
                    end else if (!ld && b && !c) begin
                        pc = 1; wr = (p == 0); p = (p + 255) % 256;
                    end
                end else if (!m_armed[i]) begin
                    arm = HOLD[i] ? !req : 1'b1;
                end
                if (b1.adh_load)     p = int'(b1.address_high_in);
                else if (b1.db_load) p = int'(b1.db_in);
                m_pch[i] <= p; m_armed[i] <= arm;
                m_done[i] <= dn; m_pc[i] <= pc; m_wrap[i] <= wr;
            end
        end
    end

    task automatic drive(input bit c, input bit b, input bit al, input logic [7:0] ai,
                         input bit dl, input logic [7:0] di);
        b1.carry_to_pch = c;  b1.borrow_to_pch = b;
        b1.adh_load = al;     b1.address_high_in = ai;
        b1.db_load = dl;      b1.db_in = di;
        b0.carry_to_pch = c;  b0.borrow_to_pch = b;
        b0.adh_load = al;     b0.address_high_in = ai;
        b0.db_load = dl;      b0.db_in = di;
    endtask

    // One rising edge, then settle to the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_pch(input logic [7:0] v);
        drive(0, 0, 1, v, 0, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step(); step();
        checks++; if (b1.address_high_out !== 8'hFF) begin errors++; $display("FAIL reset_pch: got %h want ff", b1.address_high_out); end
        checks++; if (b1.db_out !== 8'hFF) begin errors++; $display("FAIL reset_db_out: got %h want ff", b1.db_out); end
        checks++; if ({b1.carry_done, b1.page_cross, b1.pch_wrap, b1.busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {b1.carry_done, b1.page_cross, b1.pch_wrap, b1.busy}); end
        checks++; if (b0.address_high_out !== 8'h3C) begin errors++; $display("FAIL reset_pch_alt: got %h want 3c", b0.address_high_out); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_carry_hold();
        load_pch(8'h12);
        checks++; if (b1.address_high_out !== 8'h12) begin errors++; $display("FAIL load_12: got %h want 12", b1.address_high_out); end
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if (b1.address_high_out !== 8'h13) begin errors++; $display("FAIL carry_inc: got %h want 13", b1.address_high_out); end
        checks++; if ({b1.carry_done, b1.page_cross, b1.pch_wrap, b1.busy} !== 4'b1101) begin errors++; $display("FAIL carry_flags: got %b want 1101", {b1.carry_done, b1.page_cross, b1.pch_wrap, b1.busy}); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (b1.address_high_out !== 8'h13) begin errors++; $display("FAIL carry_held_pch%0d: got %h want 13", k, b1.address_high_out); end
            checks++; if ({b1.carry_done, b1.page_cross, b1.busy} !== 3'b001) begin errors++; $display("FAIL carry_held_flags%0d: got %b want 001", k, {b1.carry_done, b1.page_cross, b1.busy}); end
        end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if (b1.busy !== 1'b0 || b1.address_high_out !== 8'h13) begin errors++; $display("FAIL carry_release: busy=%b pch=%h want busy=0 pch=13", b1.busy, b1.address_high_out); end
    endtask

    task automatic test_wrap();
        load_pch(8'hFF);
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if ({b1.address_high_out, b1.page_cross, b1.pch_wrap} !== {8'h00, 2'b11}) begin errors++; $display("FAIL wrap_up: pch=%h pc=%b wrap=%b want 00 1 1", b1.address_high_out, b1.page_cross, b1.pch_wrap); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if (b1.pch_wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_once: got %b want 0", b1.pch_wrap); end
        drive(0, 1, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if ({b1.address_high_out, b1.page_cross, b1.pch_wrap} !== {8'hFF, 2'b11}) begin errors++; $display("FAIL wrap_down: pch=%h pc=%b wrap=%b want ff 1 1", b1.address_high_out, b1.page_cross, b1.pch_wrap); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
        load_pch(8'h80);
        drive(0, 1, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if ({b1.address_high_out, b1.page_cross, b1.pch_wrap} !== {8'h7F, 2'b10}) begin errors++; $display("FAIL borrow_nowrap: pch=%h pc=%b wrap=%b want 7f 1 0", b1.address_high_out, b1.page_cross, b1.pch_wrap); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
    endtask

    task automatic test_load_vs_carry();
        load_pch(8'h40);
        drive(1, 0, 1, 8'hC0, 0, 8'h00);
        step();
        checks++; if ({b1.address_high_out, b1.carry_done, b1.page_cross} !== {8'hC0, 2'b10}) begin errors++; $display("FAIL load_beats_carry: pch=%h done=%b pc=%b want c0 1 0", b1.address_high_out, b1.carry_done, b1.page_cross); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
    endtask

    task automatic test_adh_vs_db();
        drive(0, 0, 1, 8'hA5, 1, 8'h5A);
        step();
        checks++; if ({b1.address_high_out, b1.db_out} !== 16'hA5A5) begin errors++; $display("FAIL adh_beats_db: adh=%h db=%h want a5 a5", b1.address_high_out, b1.db_out); end
        drive(0, 0, 0, 8'h00, 1, 8'h5A);
        step();
        checks++; if (b1.db_out !== 8'h5A) begin errors++; $display("FAIL db_load: got %h want 5a", b1.db_out); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_carry_and_borrow();
        load_pch(8'h80);
        drive(1, 1, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if ({b1.address_high_out, b1.carry_done, b1.page_cross, b1.busy} !== {8'h80, 3'b101}) begin errors++; $display("FAIL both_req: pch=%h done=%b pc=%b busy=%b want 80 1 0 1", b1.address_high_out, b1.carry_done, b1.page_cross, b1.busy); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
    endtask

    task automatic test_reset_mid_wait();
        load_pch(8'h20);
        drive(1, 0, 0, 8'h00, 0, 8'h00);
        step();
        checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", b1.busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({b1.address_high_out, b1.busy, b1.carry_done, b1.page_cross} !== {8'hFF, 3'b000}) begin errors++; $display("FAIL async_reset: pch=%h busy=%b done=%b pc=%b want ff 0 0 0", b1.address_high_out, b1.busy, b1.carry_done, b1.page_cross); end
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({b1.address_high_out, b1.carry_done, b1.pch_wrap, b1.busy} !== {8'h00, 3'b111}) begin errors++; $display("FAIL restart_after_reset: pch=%h done=%b wrap=%b busy=%b want 00 1 1 1", b1.address_high_out, b1.carry_done, b1.pch_wrap, b1.busy); end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        step();
    endtask

    task automatic test_random();
        logic [7:0] ai, di;
        logic [12:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            ai = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            di = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, ai, $urandom_range(0, 9) == 0, di);
            step();
            got = {b1.address_high_out, b1.db_out == b1.address_high_out, b1.carry_done, b1.page_cross, b1.pch_wrap, b1.busy};
            exp = {8'(m_pch[1]), 1'b1, m_done[1], m_pc[1], m_wrap[1], !m_armed[1]};
            checks++; if (got !== exp) begin errors++; $display("FAIL random_hold cycle %0d: got %h want %h", n, got, exp); end
            got = {b0.address_high_out, b0.db_out == b0.address_high_out, b0.carry_done, b0.page_cross, b0.pch_wrap, b0.busy};
            exp = {8'(m_pch[0]), 1'b1, m_done[0], m_pc[0], m_wrap[0], !m_armed[0]};
            checks++; if (got !== exp) begin errors++; $display("FAIL random_nohold cycle %0d: got %h want %h", n, got, exp); end
        end
        drive(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 8'h00);
        test_reset();
        test_carry_hold();
        test_wrap();
        test_load_vs_carry();
        test_adh_vs_db();
        test_carry_and_borrow();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pch_sequencer.md
PCH_SEQUENCER -- requirements
Module: pch_sequencer

Interface
REQ-001 Parameter RESET_PCH, default 8'h00, value loaded into the PC high byte on reset.
REQ-002 Parameter HOLD_CHECK, default 1; when 1, an adjust request re-arms only after the request line has been seen low.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 carry_to_pch  input  1  level from PC-low stage; PCL wrapped FF->00, increment PCH.
REQ-006 borrow_to_pch  input  1  level from PC-low stage; backward page cross, decrement PCH.
REQ-007 adh_load  input  1  load PCH from address_high_in (jumps, vectors).
REQ-008 address_high_in  input  8  ADH bus value.
REQ-009 db_load  input  1  load PCH from db_in (RTS/RTI pull).
REQ-010 db_in  input  8  data bus value.
REQ-011 address_high_out  output  8  current PCH, drives ADH.
REQ-012 db_out  output  8  current PCH, for stack push.
REQ-013 carry_done  output  1  one-cycle acknowledge of a carry/borrow request.
REQ-014 page_cross  output  1  one-cycle pulse when PCH was changed by carry or borrow.
REQ-015 pch_wrap  output  1  one-cycle pulse on FF->00 increment or 00->FF decrement.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 address_high_out and db_out SHALL both equal the PCH register combinationally; no extra latency.
REQ-018 The FSM SHALL have states IDLE, WAIT_RELEASE.
REQ-019 Priority at each edge: adh_load > db_load > carry/borrow adjust.
REQ-020 Load: PCH <= selected input at that edge; value is visible on outputs the next cycle.
REQ-021 IDLE, no load, carry_to_pch=1, borrow_to_pch=0: PCH <= PCH+1 (mod 256); carry_done, page_cross <= 1 for one cycle; state -> WAIT_RELEASE.
REQ-022 IDLE, no load, borrow_to_pch=1, carry_to_pch=0: PCH <= PCH-1 (mod 256); carry_done, page_cross <= 1; -> WAIT_RELEASE.
REQ-023 IDLE, both carry and borrow high: PCH unchanged; carry_done <= 1; page_cross stays 0; -> WAIT_RELEASE.
REQ-024 pch_wrap SHALL pulse in the same cycle as page_cross only for the FF->00 or 00->FF transitions.
REQ-025 Load in the same edge as a pending carry/borrow in IDLE: load wins, adjust is discarded, carry_done still pulses once, page_cross stays 0, -> WAIT_RELEASE.
REQ-026 WAIT_RELEASE with HOLD_CHECK=1: no adjust occurs; return to IDLE on the first edge with carry_to_pch=0 and borrow_to_pch=0.
REQ-027 WAIT_RELEASE with HOLD_CHECK=0: return to IDLE unconditionally after one cycle.
REQ-028 Loads SHALL be honoured in every state.
REQ-029 carry_done, page_cross, and pch_wrap SHALL be registered, high for exactly one clk cycle per accepted request.
REQ-030 A held request never produces more than one adjust per rising edge of the request.

Reset
REQ-031 reset_n low SHALL immediately force PCH=RESET_PCH, state=IDLE, and carry_done=page_cross=pch_wrap=busy=0, independent of clk.
REQ-032 Reset asserted mid-WAIT_RELEASE SHALL discard the pending acknowledge; after release, the FSM SHALL restart in IDLE and act on any still-high request at the first edge.

Verification
REQ-033 Reset, then PCH=12, carry_to_pch held high 3 cycles -> PCH=13 after one edge, carry_done and page_cross high 1 cycle, busy high until carry low, no further increment.
REQ-034 PCH=FF, carry pulse -> PCH=00, pch_wrap=1 for one cycle; PCH=00, borrow pulse -> PCH=FF, pch_wrap=1.
REQ-035 PCH=40, adh_load=1 with address_high_in=C0 and carry_to_pch=1 in the same cycle -> PCH=C0, carry_done=1, page_cross=0.
REQ-036 adh_load=1 (A5) and db_load=1 (5A) together -> PCH=A5; db_out=address_high_out=A5.
REQ-037 Carry and borrow high together at PCH=80 -> PCH stays 80, carry_done=1, page_cross=0.
REQ-038 reset_n pulsed low while in WAIT_RELEASE with RESET_PCH=FF -> PCH=FF, busy=0 at once without a clk edge.
